// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between two requesters (m0, m1)
// using a request/grant/ack handshake, a programmable wait-state count and
// round-robin arbitration on simultaneous requests.
// Build macro ARB_FIXED_PRIORITY_EN: when defined, m0 always wins a tie and
// no last-served history is kept.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datao,
    output logic              mem_rw,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_m1_q, gnt_m1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic              busy_q, busy_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic              pick_m1;
`ifndef ARB_FIXED_PRIORITY_EN
    logic              last_m1_q, last_m1_d;
`endif

    // Arbitration decision for the current IDLE cycle
`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        pick_m1 = m1_req && !m0_req;
    end
`else
    always_comb begin
        pick_m1 = m1_req && (!m0_req || !last_m1_q);
    end
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_m1_d  = gnt_m1_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        rdata_d   = rdata_q;
        mem_en_d  = mem_en_q;
        mem_rw_d  = mem_rw_q;
        busy_d    = busy_q;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
        last_m1_d = last_m1_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d  = ACCESS;
                    gnt_m1_d = pick_m1;
                    addr_d   = pick_m1 ? m1_addr  : m0_addr;
                    wdata_d  = pick_m1 ? m1_wdata : m0_wdata;
                    rw_d     = pick_m1 ? m1_rw    : m0_rw;
                    mem_rw_d = pick_m1 ? m1_rw    : m0_rw;
                    cnt_d    = CNT_INIT;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                    mem_rw_d = 1'b1;
                    if (rw_q) begin
                        rdata_d = mem_data;
                    end
                    m0_ack_d = !gnt_m1_q;
                    m1_ack_d = gnt_m1_q;
                end
            end
            DONE: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
                last_m1_d = gnt_m1_q;
`endif
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_rw_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_m1_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            rdata_q   <= '0;
            mem_en_q  <= 1'b0;
            mem_rw_q  <= 1'b1;
            busy_q    <= 1'b0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
            last_m1_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_m1_q  <= gnt_m1_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            rdata_q   <= rdata_d;
            mem_en_q  <= mem_en_d;
            mem_rw_q  <= mem_rw_d;
            busy_q    <= busy_d;
            m0_ack_q  <= m0_ack_d;
            m1_ack_q  <= m1_ack_d;
`ifndef ARB_FIXED_PRIORITY_EN
            last_m1_q <= last_m1_d;
`endif
        end
    end

    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign rdata       = rdata_q;
    assign mem_address = addr_q;
    assign mem_datao   = wdata_q;
    assign mem_rw      = mem_rw_q;
    assign mem_en      = mem_en_q;
    assign busy        = busy_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 32-bit memory port between two requesters: m0 (cpu fetch/load/store) and m1 (program loader / DMA).
- Sits between the cpu memory interface and the memory, i.e. on the address/data/datao/rw nets.
- Runs a request/grant/ack handshake with a configurable memory wait-state count and round-robin fairness.
- Serialises exactly one memory transaction at a time.

Parameters:
- WAIT_CYCLES, 1: extra memory cycles before read data is valid; legal range 0..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  m0 transaction request; held high until m0_ack.
- m0_rw  in  1  m0 direction: 1 = read, 0 = write.
- m0_addr  in  ADDR_W  m0 address.
- m0_wdata  in  DATA_W  m0 write data.
- m0_ack  out  1  one-cycle completion pulse to m0.
- m1_req, m1_rw, m1_addr, m1_wdata, m1_ack: same as the m0 ports, for m1.
- rdata  out  DATA_W  read data for the acked requester; valid while its ack is high.
- mem_address  out  ADDR_W  memory address.
- mem_datao  out  DATA_W  memory write data.
- mem_rw  out  1  memory direction: 1 = read, 0 = write.
- mem_en  out  1  memory access strobe.
- mem_data  in  DATA_W  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM goes to IDLE.
  - All outputs are 0, except mem_rw = 1 (idle bus reads as read).
  - last_served = m1, so m0 wins the first tie.
  - Wait counter = 0; latched address, write data and rw = 0.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requesting: grant the requester that is not last_served.
  - On a grant: latch the grantee's addr, wdata and rw; record the grantee id; load cnt = WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_address, mem_datao and mem_rw are driven from the latched values.
  - If cnt != 0: cnt decrements and the FSM stays in ACCESS.
  - If cnt == 0 and read: capture mem_data into rdata at this edge; go to DONE.
  - If cnt == 0 and write: go to DONE; rdata is unchanged.
- DONE:
  - mem_en = 0; the grantee's ack = 1 for exactly this cycle.
  - last_served is updated to the grantee.
  - Return to IDLE unconditionally.
- Latency: req first high in IDLE cycle N gives ack high in cycle N + WAIT_CYCLES + 2.
  - ACCESS lasts WAIT_CYCLES + 1 cycles.
  - Minimum transaction length is 3 cycles.
- Handshake rules:
  - The requester updates req at the same edge it samples ack.
  - A req still high in the IDLE cycle after ack starts a new transaction.
  - Back-to-back streaming from one master is legal. It yields to the other master whenever both request.
- addr/wdata/rw changes after the grant have no effect on the current transaction; the values are latched.
- req dropped mid-transaction: the access completes and ack still pulses. No abort.
- Reset asserted during ACCESS: the transaction is dropped, mem_en falls immediately and no ack is issued.
- Only one of m0_ack / m1_ack is high in any cycle; both are never high together.
- Counter is 4 bits. WAIT_CYCLES = 0 goes IDLE -> ACCESS (1 cycle) -> DONE.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: m0 always wins a simultaneous request. last_served is not implemented, and m1 is granted only in IDLE cycles where m0_req = 0.
- Undefined (default): round-robin exactly as described in Behaviour.

Test Plan:
- WAIT_CYCLES = 1; reset, then m0_req = 1, rw = 1, addr = 0x10, mem_data = 0xDEADBEEF -> mem_en high in cycles 1–2; m0_ack and rdata = 0xDEADBEEF in cycle 3; busy low in cycle 4.
- m1 write, addr = 0x20, wdata = 0x1234 -> mem_rw = 0, mem_address = 0x20, mem_datao = 0x1234 during ACCESS; m1_ack pulses once; rdata unchanged.
- m0_req and m1_req both held high for 4 transactions -> grant order m0, m1, m0, m1 (default). With ARB_FIXED_PRIORITY_EN: m0 four times, m1 never acked.
- m0_addr changed from 0x40 to 0x80 one cycle after the grant -> mem_address stays 0x40 for the whole ACCESS.
- Reset pulsed in the middle of ACCESS -> mem_en = 0 and busy = 0 at once; no ack; the next m0 request after reset completes normally.
- WAIT_CYCLES = 0; m0 read -> ack exactly 2 cycles after the request cycle; mem_en high for exactly 1 cycle.
